// File: rtl/nv_ram_rws_64x512_fifo_ctl.sv
// nv_ram_rws_64x512_fifo_ctl: valid/ready FIFO controller driving an external 64x512 RAM with 1-cycle registered read
// Ports: nvdla_core_clk/nvdla_core_rstn (async active-low), wr_pvld/wr_prdy/wr_pd producer side,
// rd_pvld/rd_prdy/rd_pd consumer side, ram_we/ram_wa/ram_di write port, ram_re/ram_ra/ram_dout read port,
// fifo_count occupancy, fifo_hwm high-water mark (register only when NV_RWS_FIFO_HWM_EN is defined).
module nv_ram_rws_64x512_fifo_ctl (
  input  logic         nvdla_core_clk,
  input  logic         nvdla_core_rstn,
  input  logic         wr_pvld,
  output logic         wr_prdy,
  input  logic [511:0] wr_pd,
  output logic         rd_pvld,
  input  logic         rd_prdy,
  output logic [511:0] rd_pd,
  output logic         ram_we,
  output logic [5:0]   ram_wa,
  output logic [511:0] ram_di,
  output logic         ram_re,
  output logic [5:0]   ram_ra,
  input  logic [511:0] ram_dout,
  output logic [6:0]   fifo_count,
  output logic [6:0]   fifo_hwm
);
  logic [5:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [6:0] cnt_q, cnt_d, pending;
  logic       out_vld_q, out_vld_d, push, pop;
  always_comb begin
    wr_prdy   = nvdla_core_rstn & (cnt_q != 7'd64);
    push      = wr_pvld & wr_prdy;
    pop       = out_vld_q & rd_prdy;
    // pending excludes the presented head, so an entry is fetched only after its write has registered
    pending   = cnt_q - {6'd0, out_vld_q};
    ram_re    = nvdla_core_rstn & (pending != 7'd0) & (~out_vld_q | pop);
    wr_ptr_d  = push ? wr_ptr_q + 6'd1 : wr_ptr_q;
    rd_ptr_d  = ram_re ? rd_ptr_q + 6'd1 : rd_ptr_q;
    out_vld_d = ram_re | (out_vld_q & ~pop);
    cnt_d     = cnt_q + {6'd0, push} - {6'd0, pop};
  end
  always_ff @(posedge nvdla_core_clk or negedge nvdla_core_rstn)
    if (!nvdla_core_rstn) begin
      wr_ptr_q  <= 6'd0;
      rd_ptr_q  <= 6'd0;
      cnt_q     <= 7'd0;
      out_vld_q <= 1'b0;
    end else begin
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      cnt_q     <= cnt_d;
      out_vld_q <= out_vld_d;
    end
  assign ram_we     = push;
  assign ram_wa     = wr_ptr_q;
  assign ram_di     = wr_pd;
  assign ram_ra     = rd_ptr_q;
  assign rd_pvld    = out_vld_q;
  assign rd_pd      = ram_dout;
  assign fifo_count = cnt_q;
`ifdef NV_RWS_FIFO_HWM_EN
  logic [6:0] hwm_q, hwm_d;
  always_comb hwm_d = (cnt_d > hwm_q) ? cnt_d : hwm_q;
  always_ff @(posedge nvdla_core_clk or negedge nvdla_core_rstn)
    if (!nvdla_core_rstn) hwm_q <= 7'd0;
    else hwm_q <= hwm_d;
  assign fifo_hwm = hwm_q;
`else
  assign fifo_hwm = 7'd0;
`endif
endmodule

// File: tb/tb_nv_ram_rws_64x512_fifo_ctl.sv
// tb_nv_ram_rws_64x512_fifo_ctl: directed self-checking bench with a behavioural 64x512 RAM
module tb_nv_ram_rws_64x512_fifo_ctl;
  logic         clk = 1'b0;
  logic         rstn, wr_pvld, wr_prdy, rd_pvld, rd_prdy, ram_we, ram_re;
  logic [511:0] wr_pd, rd_pd, ram_di, ram_dout;
  logic [5:0]   ram_wa, ram_ra;
  logic [6:0]   fifo_count, fifo_hwm;
  logic [511:0] mem [64];
  int checks = 0;
  int errors = 0;
  always #5 clk = ~clk;
  nv_ram_rws_64x512_fifo_ctl dut (
    .nvdla_core_clk(clk), .nvdla_core_rstn(rstn),
    .wr_pvld(wr_pvld), .wr_prdy(wr_prdy), .wr_pd(wr_pd),
    .rd_pvld(rd_pvld), .rd_prdy(rd_prdy), .rd_pd(rd_pd),
    .ram_we(ram_we), .ram_wa(ram_wa), .ram_di(ram_di),
    .ram_re(ram_re), .ram_ra(ram_ra), .ram_dout(ram_dout),
    .fifo_count(fifo_count), .fifo_hwm(fifo_hwm)
  );
  always @(posedge clk) begin
    if (ram_we) mem[ram_wa] <= ram_di;
    if (ram_re) ram_dout <= mem[ram_ra];
  end
  task automatic chk(input string tag, input logic [511:0] got, input logic [511:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h exp %0h", tag, got, exp);
    end
  endtask
  task automatic do_reset;
    @(negedge clk);
    rstn = 1'b0;
    wr_pvld = 1'b0;
    rd_prdy = 1'b0;
    @(negedge clk);
    rstn = 1'b1;
  endtask
  initial begin
    rstn = 1'b0;
    wr_pvld = 1'b1;
    rd_prdy = 1'b0;
    wr_pd = '1;
    ram_dout = '0;
    @(negedge clk);
    @(negedge clk);
    #1;
    chk("rst_wr_prdy", wr_prdy, 0);
    chk("rst_rd_pvld", rd_pvld, 0);
    chk("rst_count", fifo_count, 0);
    chk("rst_hwm", fifo_hwm, 0);
    chk("rst_we", ram_we, 0);
    chk("rst_re", ram_re, 0);
    chk("rst_ra", ram_ra, 0);
    chk("rst_wa", ram_wa, 0);
    rstn = 1'b1;
    wr_pvld = 1'b0;
    #1 chk("wr_prdy_up", wr_prdy, 1);
    @(negedge clk);
    wr_pvld = 1'b1;
    wr_pd = {64{8'hA5}};
    #1 chk("single_we", ram_we, 1);
    chk("single_wa", ram_wa, 0);
    @(negedge clk);
    wr_pvld = 1'b0;
    #1 chk("single_re", ram_re, 1);
    chk("single_ra", ram_ra, 0);
    chk("single_cnt1", fifo_count, 1);
    chk("single_nopvld", rd_pvld, 0);
    @(negedge clk);
    rd_prdy = 1'b1;
    #1 chk("single_pvld", rd_pvld, 1);
    chk("single_pd", rd_pd, {64{8'hA5}});
    chk("single_cnt2", fifo_count, 1);
    @(negedge clk);
    rd_prdy = 1'b0;
    #1 chk("single_empty", rd_pvld, 0);
    chk("single_cnt0", fifo_count, 0);
    do_reset();
    for (int i = 0; i < 64; i++) begin
      @(negedge clk);
      wr_pvld = 1'b1;
      wr_pd = 512'(i);
    end
    @(negedge clk);
    wr_pd = 512'd64;
    #1 chk("full_prdy", wr_prdy, 0);
    chk("full_cnt", fifo_count, 64);
    chk("full_we", ram_we, 0);
    chk("full_head", rd_pd, 0);
    rd_prdy = 1'b1;
    #1 chk("full_pop_re", ram_re, 1);
    @(negedge clk);
    rd_prdy = 1'b0;
    #1 chk("unfull_prdy", wr_prdy, 1);
    chk("wrap_wa", ram_wa, 0);
    chk("wrap_we", ram_we, 1);
    chk("unfull_head", rd_pd, 1);
    chk("unfull_cnt", fifo_count, 63);
    @(negedge clk);
    wr_pvld = 1'b0;
    rd_prdy = 1'b1;
    #1 chk("refull_cnt", fifo_count, 64);
    for (int k = 1; k <= 64; k++) begin
      chk("drain_pd", rd_pd, 512'(k));
      @(negedge clk);
      #1;
    end
    chk("drain_empty", rd_pvld, 0);
    chk("drain_cnt", fifo_count, 0);
    for (int i = 0; i < 204; i++) begin
      wr_pvld = (i < 200);
      wr_pd = 512'(1000 + i);
      #1;
      if (i >= 2 && i < 202) chk("stream_pd", rd_pd, 512'(1000 + i - 2));
      if (i >= 2 && i < 200) chk("stream_cnt", fifo_count, 2);
      @(negedge clk);
    end
    wr_pvld = 1'b0;
    #1 chk("stream_end_cnt", fifo_count, 0);
    chk("stream_end_pvld", rd_pvld, 0);
    rd_prdy = 1'b0;
    wr_pvld = 1'b1;
    wr_pd = 512'h77;
    @(negedge clk);
    wr_pvld = 1'b0;
    #1 chk("stall_fetch", ram_re, 1);
    @(negedge clk);
    for (int j = 0; j < 10; j++) begin
      wr_pvld = 1'b1;
      wr_pd = 512'(256 + j);
      #1 chk("stall_pd", rd_pd, 512'h77);
      chk("stall_re", ram_re, 0);
      chk("stall_pvld", rd_pvld, 1);
      @(negedge clk);
    end
    for (int j = 0; j < 9; j++) begin
      wr_pd = 512'(300 + j);
      @(negedge clk);
    end
    wr_pvld = 1'b0;
    #1 chk("queued_cnt", fifo_count, 20);
    rstn = 1'b0;
    #1 chk("mid_rst_pvld", rd_pvld, 0);
    chk("mid_rst_cnt", fifo_count, 0);
    chk("mid_rst_prdy", wr_prdy, 0);
    @(negedge clk);
    rstn = 1'b1;
    wr_pvld = 1'b1;
    wr_pd = 512'hBEEF;
    #1 chk("post_rst_wa", ram_wa, 0);
    chk("post_rst_we", ram_we, 1);
    @(negedge clk);
    wr_pvld = 1'b0;
    #1 chk("post_rst_ra", ram_ra, 0);
    chk("post_rst_re", ram_re, 1);
    @(negedge clk);
    #1 chk("post_rst_pd", rd_pd, 512'hBEEF);
    do_reset();
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      wr_pvld = 1'b1;
      wr_pd = 512'(i);
    end
    @(negedge clk);
    wr_pvld = 1'b0;
    rd_prdy = 1'b1;
    for (int i = 0; i < 30; i++) @(negedge clk);
    rd_prdy = 1'b0;
    wr_pvld = 1'b1;
    for (int i = 0; i < 10; i++) @(negedge clk);
    wr_pvld = 1'b0;
    #1 chk("hwm_cnt", fifo_count, 20);
`ifdef NV_RWS_FIFO_HWM_EN
    chk("hwm", fifo_hwm, 40);
`else
    chk("hwm", fifo_hwm, 0);
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
